// File: rtl/prio_encoder_q.sv
// N-input priority encoder with sticky request capture and a registered valid/ready grant.
// Define PRIO_ENC_RR_EN for round-robin selection; default is fixed priority (highest index wins).
module prio_encoder_q #(
    parameter int N     = 8,
    parameter int OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     din,
    input  logic             ready,
    output logic [OUT_W-1:0] dout,
    output logic             valid,
    output logic [N-1:0]     pend,
    output logic             busy
);

    if (OUT_W != $clog2(N)) begin : g_bad_width
        $error("prio_encoder_q: OUT_W must equal clog2(N)");
    end
    if (N < 2) begin : g_bad_n
        $error("prio_encoder_q: N must be at least 2");
    end

    logic [OUT_W-1:0] sel;
    logic             slot_free;
    logic             grant;
    logic [N-1:0]     gnt_mask;

    // A grant may be issued when the output slot is empty or being accepted this cycle.
    assign slot_free = ~valid | ready;
    assign grant     = slot_free & (|pend);
    assign gnt_mask  = grant ? (N'(1) << sel) : '0;
    assign busy      = (|pend) | valid;

`ifdef PRIO_ENC_RR_EN
    logic [OUT_W-1:0] ptr;

    // Descending search from ptr with wrap; later iterations are closer to ptr and override.
    always_comb begin
        int               idx;
        logic [OUT_W-1:0] cand;
        sel  = '0;
        idx  = 0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) - i;
            if (idx < 0) begin
                idx = idx + N;
            end
            cand = OUT_W'(idx);
            if (pend[cand]) begin
                sel = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= OUT_W'(N - 1);
        end else if (grant) begin
            ptr <= (sel == '0) ? OUT_W'(N - 1) : sel - 1'b1;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                sel = OUT_W'(i);
            end
        end
    end
`endif

    // New requests are OR-ed in after the grant clear, so a same-cycle set survives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend  <= '0;
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            pend <= (pend & ~gnt_mask) | (en ? din : '0);
            if (slot_free) begin
                valid <= |pend;
                if (|pend) begin
                    dout <= sel;
                end
            end
        end
    end

endmodule
